// File: rtl/dyn_branch_predictor.sv
// -----------------------------------------------------------------------------
// dyn_branch_predictor
//
// Dynamic branch direction predictor for the 5-stage MIPS pipeline.
// A pattern history table (PHT) of saturating counters is looked up with the
// fetch PC. The index is bimodal (PC only) or gshare (PC xor global history).
// The prediction is registered into decode. Branches resolved in decode train
// the table. After reset, an initialisation sweep writes every entry to
// weakly-not-taken before the predictor reports ready.
//
// Optional feature: define BP_STATS_EN to add branch and mispredict counters.
//
// Ports
//   clk              in   rising-edge clock
//   rst              in   synchronous reset, active-high
//   pcF              in   fetch-stage PC to predict
//   stallD           in   hold the decode-side prediction registers
//   flushD           in   invalidate the decode-side prediction (wins over stall)
//   upd_valid        in   a branch was resolved in decode this cycle
//   upd_idx          in   PHT index of that branch (echo of pred_idxD)
//   upd_taken        in   actual outcome of that branch
//   upd_mispredict   in   that branch was mispredicted (statistics only)
//   ready            out  PHT initialisation sweep complete
//   pred_validD      out  pred_takenD / pred_idxD are meaningful
//   pred_takenD      out  predicted direction for the PC now in decode
//   pred_idxD        out  PHT index used for that prediction
//   ghr              out  global history, newest outcome in bit 0
//   stat_branches    out  (BP_STATS_EN) resolved branches since reset
//   stat_mispredicts out  (BP_STATS_EN) mispredicted branches since reset
// -----------------------------------------------------------------------------
module dyn_branch_predictor #(
   parameter int PHT_IDX_W = 10,
   parameter int GHR_W     = 8,
   parameter int CNT_W     = 2,
   parameter int MODE      = 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [31:0]          pcF,
   input  logic                 stallD,
   input  logic                 flushD,
   input  logic                 upd_valid,
   input  logic [PHT_IDX_W-1:0] upd_idx,
   input  logic                 upd_taken,
   input  logic                 upd_mispredict,
   output logic                 ready,
   output logic                 pred_validD,
   output logic                 pred_takenD,
   output logic [PHT_IDX_W-1:0] pred_idxD,
   output logic [GHR_W-1:0]     ghr
`ifdef BP_STATS_EN
   ,
   output logic [31:0]          stat_branches,
   output logic [31:0]          stat_mispredicts
`endif
);

   localparam int                   ENTRIES  = 2 ** PHT_IDX_W;
   localparam logic [CNT_W-1:0]     CNT_MAX  = '1;
   localparam logic [CNT_W-1:0]     CNT_WNT  = CNT_W'((2 ** (CNT_W - 1)) - 1);
   localparam logic [PHT_IDX_W-1:0] LAST_IDX = '1;

   typedef enum logic {
      S_INIT,
      S_READY
   } state_t;

   state_t               state, state_next;
   logic [PHT_IDX_W-1:0] sweep;

   logic [CNT_W-1:0]     pht [ENTRIES];

   logic [PHT_IDX_W-1:0] base, ghr_ext, lookup_idx;
   logic                 upd_en;
   logic [CNT_W-1:0]     upd_old, upd_new;
   logic                 lookup_taken;

   logic                 pht_we;
   logic [PHT_IDX_W-1:0] pht_waddr;
   logic [CNT_W-1:0]     pht_wdata;

   // PC bits outside the index and the stats-only input are not needed here.
   logic unused_inputs;
   assign unused_inputs = ^{pcF[31:PHT_IDX_W+2], pcF[1:0], upd_mispredict};

   // ---------------------------------------------------------------- FSM
   // NOTE: sequential state uses non-blocking (<=) so every register samples
   // the pre-edge values of its neighbours, independent of block order.
   always_ff @(posedge clk) begin
      if (rst) state <= S_INIT;
      else     state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         S_INIT:  if (sweep == LAST_IDX) state_next = S_READY;
         S_READY: state_next = S_READY;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst)                  sweep <= '0;
      else if (state == S_INIT) sweep <= sweep + 1'b1;
   end

   assign ready  = (state == S_READY);
   assign upd_en = ready && upd_valid;

   // -------------------------------------------------------------- Index
   assign base       = pcF[PHT_IDX_W+1:2];
   assign ghr_ext    = PHT_IDX_W'(ghr);
   assign lookup_idx = (MODE == 0) ? base : (base ^ ghr_ext);

   // ---------------------------------------------------- Counter update
   assign upd_old = pht[upd_idx];

   // NOTE: every always_comb output gets a default first, so no path can
   // leave it unassigned and infer a latch.
   always_comb begin
      upd_new = upd_old;
      if (upd_taken) begin
         if (upd_old != CNT_MAX) upd_new = upd_old + 1'b1;
      end else begin
         if (upd_old != '0)      upd_new = upd_old - 1'b1;
      end
   end

   // Single write port shared by the init sweep and training.
   always_comb begin
      pht_we    = 1'b0;
      pht_waddr = upd_idx;
      pht_wdata = upd_new;
      if (state == S_INIT) begin
         pht_we    = !rst;
         pht_waddr = sweep;
         pht_wdata = CNT_WNT;
      end else if (upd_en) begin
         pht_we    = 1'b1;
      end
   end

   // NOTE: the table has no reset; the INIT sweep is what gives it known
   // contents, which keeps it mappable onto plain RAM.
   always_ff @(posedge clk) begin
      if (pht_we) pht[pht_waddr] <= pht_wdata;
   end

   // Write-first: a lookup hitting the entry being trained sees the new value.
   assign lookup_taken = (upd_en && (upd_idx == lookup_idx)) ? upd_new[CNT_W-1]
                                                             : pht[lookup_idx][CNT_W-1];

   // ------------------------------------------------- Decode prediction
   always_ff @(posedge clk) begin
      if (rst) begin
         pred_validD <= 1'b0;
         pred_takenD <= 1'b0;
         pred_idxD   <= '0;
      end else if (state == S_READY) begin
         if (!stallD) begin
            pred_validD <= 1'b1;
            pred_takenD <= lookup_taken;
            pred_idxD   <= lookup_idx;
         end
         // Placed last so a flush overrides both a new lookup and a stall.
         if (flushD) begin
            pred_validD <= 1'b0;
            pred_takenD <= 1'b0;
         end
      end
   end

   // Non-speculative history: shifts only on resolved branches.
   always_ff @(posedge clk) begin
      if (rst)         ghr <= '0;
      else if (upd_en) ghr <= {ghr[GHR_W-2:0], upd_taken};
   end

`ifdef BP_STATS_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         stat_branches    <= '0;
         stat_mispredicts <= '0;
      end else if (upd_en) begin
         stat_branches <= stat_branches + 32'd1;
         if (upd_mispredict) stat_mispredicts <= stat_mispredicts + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_dyn_branch_predictor.sv
// -----------------------------------------------------------------------------
// tb_dyn_branch_predictor
//
// Directed bench for dyn_branch_predictor in its default gshare configuration.
// A table of hand-computed vectors covers lookup, training, saturation at both
// ends, gshare indexing and the write-first bypass; hand-written sequences
// cover the init sweep, stall/flush and a reset issued mid-sweep.
// -----------------------------------------------------------------------------
module tb_dyn_branch_predictor;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] pcF;
   logic        stallD, flushD;
   logic        upd_valid, upd_taken, upd_mispredict;
   logic [9:0]  upd_idx;
   logic        ready, pred_validD, pred_takenD;
   logic [9:0]  pred_idxD;
   logic [7:0]  ghr;
`ifdef BP_STATS_EN
   logic [31:0] stat_branches, stat_mispredicts;
`endif

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   dyn_branch_predictor #(
      .PHT_IDX_W(10),
      .GHR_W    (8),
      .CNT_W    (2),
      .MODE     (1)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .pcF           (pcF),
      .stallD        (stallD),
      .flushD        (flushD),
      .upd_valid     (upd_valid),
      .upd_idx       (upd_idx),
      .upd_taken     (upd_taken),
      .upd_mispredict(upd_mispredict),
      .ready         (ready),
      .pred_validD   (pred_validD),
      .pred_takenD   (pred_takenD),
      .pred_idxD     (pred_idxD),
      .ghr           (ghr)
`ifdef BP_STATS_EN
      ,
      .stat_branches   (stat_branches),
      .stat_mispredicts(stat_mispredicts)
`endif
   );

   typedef struct {
      logic        uv;
      logic [9:0]  ui;
      logic        ut;
      logic [31:0] pc;
      logic [9:0]  e_idx;
      logic        e_taken;
      logic [7:0]  e_ghr;
   } vec_t;

   vec_t vecs[14];

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Steps until ready rises; a missing ready shows up as a wrong count.
   task automatic wait_ready(output int n);
      n = 0;
      while (ready !== 1'b1 && n < 2000) begin
         step();
         n++;
      end
   endtask

   initial begin
      int   n;
      logic seq_t [5];
      logic seq_m [5];

      // After init every counter is 01 and ghr starts at 0.
      // Lookup idx = pcF[11:2] ^ ghr (pre-update ghr).
      vecs[0]  = '{1'b0, 10'd0, 1'b0, 32'h00400000, 10'h000, 1'b0, 8'h00};
      vecs[1]  = '{1'b0, 10'd0, 1'b0, 32'h00400014, 10'h005, 1'b0, 8'h00};
      vecs[2]  = '{1'b1, 10'd5, 1'b1, 32'h00400000, 10'h000, 1'b0, 8'h01}; // c5 1->2
      vecs[3]  = '{1'b1, 10'd5, 1'b1, 32'h00400000, 10'h001, 1'b0, 8'h03}; // c5 2->3
      vecs[4]  = '{1'b0, 10'd0, 1'b0, 32'h00400010, 10'h007, 1'b0, 8'h03}; // gshare 4^3
      vecs[5]  = '{1'b1, 10'd5, 1'b1, 32'h00400000, 10'h003, 1'b0, 8'h07}; // c5 stays 3
      vecs[6]  = '{1'b0, 10'd0, 1'b0, 32'h00400008, 10'h005, 1'b1, 8'h07}; // read c5=3
      vecs[7]  = '{1'b1, 10'd5, 1'b0, 32'h00400008, 10'h005, 1'b1, 8'h0E}; // c5 3->2
      vecs[8]  = '{1'b1, 10'd5, 1'b0, 32'h0040002C, 10'h005, 1'b0, 8'h1C}; // c5 2->1 bypass
      vecs[9]  = '{1'b1, 10'd5, 1'b0, 32'h00400040, 10'h00C, 1'b0, 8'h38}; // c5 1->0
      vecs[10] = '{1'b1, 10'd5, 1'b0, 32'h00400000, 10'h038, 1'b0, 8'h70}; // c5 stays 0
      vecs[11] = '{1'b1, 10'd5, 1'b1, 32'h004001D4, 10'h005, 1'b0, 8'hE1}; // c5 0->1
      vecs[12] = '{1'b1, 10'd5, 1'b1, 32'h00400390, 10'h005, 1'b1, 8'hC3}; // c5 1->2
      vecs[13] = '{1'b1, 10'd9, 1'b1, 32'h00400328, 10'h009, 1'b1, 8'h87}; // c9 1->2 bypass

      rst = 1'b1; pcF = 32'h00400000; stallD = 1'b0; flushD = 1'b0;
      upd_valid = 1'b0; upd_idx = '0; upd_taken = 1'b0; upd_mispredict = 1'b0;
      step();
      check("reset_ready", ready, 0);
      check("reset_valid", pred_validD, 0);
      check("reset_taken", pred_takenD, 0);
      check("reset_idx",   pred_idxD, 0);
      check("reset_ghr",   ghr, 0);

      // Updates during the sweep must be ignored.
      rst = 1'b0; upd_valid = 1'b1; upd_idx = 10'd0; upd_taken = 1'b1; upd_mispredict = 1'b1;
      wait_ready(n);
      check("init_cycles", n, 1024);
      check("init_ghr", ghr, 0);
      check("init_valid", pred_validD, 0);
`ifdef BP_STATS_EN
      check("init_stat_br", stat_branches, 0);
      check("init_stat_mp", stat_mispredicts, 0);
`endif
      upd_valid = 1'b0; upd_mispredict = 1'b0;

      for (int i = 0; i < 14; i++) begin
         upd_valid = vecs[i].uv;
         upd_idx   = vecs[i].ui;
         upd_taken = vecs[i].ut;
         pcF       = vecs[i].pc;
         step();
         check($sformatf("row%0d_valid", i), pred_validD, 1);
         check($sformatf("row%0d_taken", i), pred_takenD, vecs[i].e_taken);
         check($sformatf("row%0d_idx", i),   pred_idxD,   vecs[i].e_idx);
         check($sformatf("row%0d_ghr", i),   ghr,         vecs[i].e_ghr);
      end
      upd_valid = 1'b0;

      // Stall holds the idx-9 prediction while pcF moves.
      stallD = 1'b1;
      for (int i = 0; i < 3; i++) begin
         pcF = 32'h00400000 + 32'(i * 4);
         step();
         check($sformatf("stall%0d_valid", i), pred_validD, 1);
         check($sformatf("stall%0d_taken", i), pred_takenD, 1);
         check($sformatf("stall%0d_idx", i),   pred_idxD,   10'h009);
      end
      flushD = 1'b1;
      step();
      check("flush_stall_valid", pred_validD, 0);
      check("flush_stall_taken", pred_takenD, 0);
      stallD = 1'b0; flushD = 1'b0; pcF = 32'h00400000;
      step();
      check("resume_valid", pred_validD, 1);
      check("resume_idx",   pred_idxD,   10'h087);
      check("resume_taken", pred_takenD, 0);
      flushD = 1'b1;
      step();
      check("flush_valid", pred_validD, 0);
      flushD = 1'b0;

      // Reset part-way through the sweep restarts it from entry 0.
      rst = 1'b1;
      step();
      rst = 1'b0;
      repeat (300) step();
      check("mid_init_ready", ready, 0);
      rst = 1'b1;
      step();
      check("rerst_ghr", ghr, 0);
      rst = 1'b0;
      wait_ready(n);
      check("reinit_cycles", n, 1024);
      pcF = 32'h00400014;
      step();
      check("reinit_idx",   pred_idxD,   10'h005);
      check("reinit_taken", pred_takenD, 0);

      seq_t = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
      seq_m = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
      for (int i = 0; i < 5; i++) begin
         upd_valid = 1'b1; upd_idx = 10'd20;
         upd_taken = seq_t[i]; upd_mispredict = seq_m[i];
         step();
      end
      upd_valid = 1'b0; upd_mispredict = 1'b0;
      check("hist_ghr", ghr, 8'h16);
`ifdef BP_STATS_EN
      check("stat_branches",    stat_branches,    5);
      check("stat_mispredicts", stat_mispredicts, 2);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
